// File: rtl/clk_tick_pkg.sv
// Shared definitions for the slow-clock tick recovery block.
package clk_tick_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_CHECK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  // A missing edge is declared once the counter reaches this many ratios.
  localparam int TIMEOUT_MULT = 2;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser plus a delay flop; flags the cycle after a rising edge settles.
module sync_rise_detect (
  input  logic iClk,
  input  logic iRst,
  input  logic iAsync,
  output logic oRise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= iAsync;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign oRise = r_s2 & ~r_s3;

endmodule

// File: rtl/clk_tick_recover.sv
// Turns a slow asynchronous square wave into a one-cycle enable, measures its
// period and tracks lock against the expected ratio.
module clk_tick_recover
  import clk_tick_pkg::*;
#(
  parameter int RATIO      = 10,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int WIDTH      = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iSlowClk,
  output logic             oTick,
  output logic [WIDTH-1:0] oPeriod,
  output logic             oLocked,
  output logic             oErr,
  output logic [1:0]       oDbgState
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT_MULT * RATIO);
  localparam logic [WIDTH:0]   RATIO_X     = (WIDTH+1)'(RATIO);
  localparam logic [WIDTH:0]   TOL_X       = (WIDTH+1)'(TOL);
  localparam logic [MW-1:0]    LOCK_TARGET = MW'(LOCK_COUNT);

  logic             w_rise;
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_cnt;
  logic [MW-1:0]    r_match_cnt;
  logic [MW-1:0]    w_match_inc;
  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_diff;
  logic             w_match;
  logic             w_timeout;
  logic             w_measure;
  logic             w_compare;
  logic             w_err;
  logic             w_inc_match;
  logic             w_clr_match;
  logic             r_tick;
  logic             r_err;
  logic             r_locked;
  logic [WIDTH-1:0] r_period;

  sync_rise_detect u_sync (
    .iClk   (iClk),
    .iRst   (iRst),
    .iAsync (iSlowClk),
    .oRise  (w_rise)
  );

  // Distance from the ratio is taken one bit wider so it can never wrap.
  assign w_cnt_x     = {1'b0, r_cnt};
  assign w_diff      = (w_cnt_x >= RATIO_X) ? (w_cnt_x - RATIO_X) : (RATIO_X - w_cnt_x);
  assign w_match     = (w_diff <= TOL_X);
  assign w_timeout   = (r_state != S_IDLE) && !w_rise && (r_cnt == TIMEOUT_CNT);
  assign w_match_inc = r_match_cnt + MW'(1);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_next = S_FIRST;
      end
      S_FIRST: begin
        if (w_rise)         w_next = S_CHECK;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_CHECK: begin
        if (w_rise) begin
          if (w_match && (w_match_inc == LOCK_TARGET)) w_next = S_LOCKED;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (w_rise) begin
          if (!w_match) w_next = S_CHECK;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_measure   = w_rise && (r_state != S_IDLE);
    w_compare   = w_rise && ((r_state == S_CHECK) || (r_state == S_LOCKED));
    w_err       = w_timeout || (w_compare && !w_match);
    w_inc_match = w_compare && w_match && (r_state == S_CHECK);
    w_clr_match = w_err || (r_state == S_IDLE) || (r_state == S_FIRST);
  end

  // An edge restarts the count even from idle so the first period is exact.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= WIDTH'(1);
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_match_cnt <= '0;
    end else if (w_clr_match) begin
      r_match_cnt <= '0;
    end else if (w_inc_match) begin
      r_match_cnt <= w_match_inc;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_tick   <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
      r_period <= '0;
    end else begin
      r_tick   <= w_rise;
      r_err    <= w_err;
      r_locked <= (r_state == S_LOCKED);
      if (w_measure) r_period <= r_cnt;
    end
  end

  assign oTick     = r_tick;
  assign oErr      = r_err;
  assign oLocked   = r_locked;
  assign oPeriod   = r_period;
  assign oDbgState = r_state;

endmodule

// File: tb/tb_clk_tick_recover.sv
// Scoreboard bench: two instances (TOL=0 and TOL=1) share one slow-clock stream.
module tb_clk_tick_recover;
  import clk_tick_pkg::*;

  localparam int RATIO = 10;
  localparam int LOCK  = 4;
  localparam int W     = 8;

  typedef struct packed {
    logic         tick;
    logic         err;
    logic [W-1:0] period;
    logic         locked;
    logic         chk_delta;
    logic [15:0]  delta;
  } item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic slow  = 1'b0;

  logic         tick0, err0, lock0, tick1, err1, lock1;
  logic [W-1:0] per0, per1;
  logic [1:0]   st0, st1;

  always #5 clk = ~clk;

  clk_tick_recover #(.RATIO(RATIO), .TOL(0), .LOCK_COUNT(LOCK), .WIDTH(W)) dut0 (
    .iClk(clk), .iRst(rst_n), .iSlowClk(slow), .oTick(tick0), .oPeriod(per0),
    .oLocked(lock0), .oErr(err0), .oDbgState(st0)
  );

  clk_tick_recover #(.RATIO(RATIO), .TOL(1), .LOCK_COUNT(LOCK), .WIDTH(W)) dut1 (
    .iClk(clk), .iRst(rst_n), .iSlowClk(slow), .oTick(tick1), .oPeriod(per1),
    .oLocked(lock1), .oErr(err1), .oDbgState(st1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  item_t exp_q0[$];
  item_t exp_q1[$];

  // Reference model state, one slot per instance.
  int   tol_of[2] = '{0, 1};
  bit   active[2];
  bit   locked_m[2];
  bit   have_evt[2];
  int   n_edges[2];
  int   streak[2];
  int   last_rise[2];
  int   last_period[2];
  int   last_evt[2];
  logic prev_lvl;

  bit   pend[2];
  logic pend_val[2];
  int   last_cyc[2];

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0d required=%0d", name, inst, act, req);
    end
  endtask

  task automatic push(input int i, input item_t it);
    if (i == 0) exp_q0.push_back(it);
    else        exp_q1.push_back(it);
  endtask

  // Event-level model: edge times in, expected output events out.
  task automatic model_step(input int i, input bit rise, input int t);
    item_t it;
    int p;
    int d;
    it = '0;
    if (rise) begin
      it.tick      = 1'b1;
      it.chk_delta = have_evt[i];
      it.delta     = 16'(t - last_evt[i]);
      if (!active[i]) begin
        active[i]   = 1'b1;
        n_edges[i]  = 1;
        streak[i]   = 0;
        locked_m[i] = 1'b0;
      end else begin
        p = t - last_rise[i];
        n_edges[i]++;
        last_period[i] = p;
        if (n_edges[i] > 2) begin
          d = (p > RATIO) ? p - RATIO : RATIO - p;
          if (d <= tol_of[i]) begin
            streak[i]++;
            if (streak[i] >= LOCK) locked_m[i] = 1'b1;
          end else begin
            it.err      = 1'b1;
            streak[i]   = 0;
            locked_m[i] = 1'b0;
          end
        end
      end
      last_rise[i] = t;
      it.period    = W'(last_period[i]);
      it.locked    = locked_m[i];
      push(i, it);
      last_evt[i] = t;
      have_evt[i] = 1'b1;
    end else if (active[i] && (t - last_rise[i] == 2 * RATIO)) begin
      it.err       = 1'b1;
      it.chk_delta = have_evt[i];
      it.delta     = 16'(t - last_evt[i]);
      it.period    = W'(last_period[i]);
      active[i]    = 1'b0;
      locked_m[i]  = 1'b0;
      streak[i]    = 0;
      it.locked    = 1'b0;
      push(i, it);
      last_evt[i] = t;
      have_evt[i] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    bit rise;
    cyc++;
    if (!rst_n) begin
      prev_lvl = 1'b0;
      for (int i = 0; i < 2; i++) begin
        active[i]      = 1'b0;
        locked_m[i]    = 1'b0;
        have_evt[i]    = 1'b0;
        streak[i]      = 0;
        last_period[i] = 0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      rise     = slow && !prev_lvl;
      prev_lvl = slow;
      for (int i = 0; i < 2; i++) model_step(i, rise, cyc);
    end
  end

  task automatic mon_step(input int i, input logic tk, input logic er, input logic lk, input logic [W-1:0] pd);
    item_t it;
    bit    empty;
    if (pend[i]) begin
      chk("locked_after", i, 32'(lk), 32'(pend_val[i]));
      pend[i] = 1'b0;
    end
    if (tk || er) begin
      empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
        total++;
        bad++;
        $display("FAIL unexpected_event dut%0d actual=tick%0b_err%0b required=none", i, tk, er);
      end else begin
        if (i == 0) it = exp_q0.pop_front();
        else        it = exp_q1.pop_front();
        chk("tick", i, 32'(tk), 32'(it.tick));
        chk("err", i, 32'(er), 32'(it.err));
        chk("period", i, 32'(pd), 32'(it.period));
        if (it.chk_delta) chk("spacing", i, 32'(cyc - last_cyc[i]), 32'(it.delta));
        pend[i]     = 1'b1;
        pend_val[i] = it.locked;
      end
      last_cyc[i] = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      mon_step(0, tick0, err0, lock0, per0);
      mon_step(1, tick1, err1, lock1, per1);
    end
  end

  task automatic hold(input logic lvl, input int n);
    slow = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int hi, input int lo);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tick"}, 0, 32'(tick0), 32'd0);
    chk({tag, "_err"}, 0, 32'(err0), 32'd0);
    chk({tag, "_period"}, 0, 32'(per0), 32'd0);
    chk({tag, "_locked"}, 0, 32'(lock0), 32'd0);
    chk({tag, "_state"}, 0, 32'(st0), 32'(S_IDLE));
    chk({tag, "_tick"}, 1, 32'(tick1), 32'd0);
    chk({tag, "_period"}, 1, 32'(per1), 32'd0);
    chk({tag, "_locked"}, 1, 32'(lock1), 32'd0);
  endtask

  initial begin
    int hi;
    int lo;
    rst_n = 1'b0;
    slow  = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_zero("reset");
    rst_n = 1'b1;

    // Nominal 5/5 wave.
    repeat (10) drive(5, 5);
    chk("nominal_locked", 0, 32'(lock0), 32'd1);
    chk("nominal_locked", 1, 32'(lock1), 32'd1);
    chk("nominal_period", 0, 32'(per0), 32'd10);

    // One short period, then recovery.
    drive(3, 4);
    repeat (6) drive(5, 5);
    chk("relock", 0, 32'(lock0), 32'd1);

    // Input stops.
    hold(1'b0, 30);
    chk("stop_state", 0, 32'(st0), 32'(S_IDLE));
    chk("stop_locked", 0, 32'(lock0), 32'd0);
    chk("stop_period", 0, 32'(per0), 32'd10);
    chk("stop_state", 1, 32'(st1), 32'(S_IDLE));

    // Period of exactly the timeout length.
    repeat (8) drive(5, 5);
    drive(10, 10);
    hold(1'b1, 5);
    chk("coincide_period", 0, 32'(per0), 32'd20);
    chk("coincide_state", 0, 32'(st0), 32'(S_CHECK));
    hold(1'b0, 5);
    repeat (6) drive(5, 5);

    // Asynchronous reset while the slow clock is high.
    hold(1'b1, 4);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 1);
    hold(1'b0, 5);
    repeat (7) drive(5, 5);
    chk("post_reset_locked", 0, 32'(lock0), 32'd1);

    // Alternating 9/11 periods.
    repeat (12) begin
      drive(4, 5);
      drive(5, 6);
    end
    chk("alt_locked_tol1", 1, 32'(lock1), 32'd1);
    chk("alt_locked_tol0", 0, 32'(lock0), 32'd0);

    // Random periods with occasional long gaps.
    repeat (60) begin
      hi = $urandom_range(2, 7);
      lo = $urandom_range(2, 7);
      if ($urandom_range(0, 7) == 0) lo += 12;
      drive(hi, lo);
    end
    hold(1'b0, 30);

    chk("queue_drained", 0, 32'(exp_q0.size()), 32'd0);
    chk("queue_drained", 1, 32'(exp_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
